pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Fetch sequencer for the 32-bit program counter.
- Drives the PC's hold/pc_sel/next_pc controls and runs the instruction-memory request/grant/response handshake.
- Arbitrates redirect sources (trap > branch > jump) and delivers one fetched instruction at a time to the IF/ID boundary.
- Sits between the PC register, instruction memory and the decode stage.

Parameters:
TRAP_VEC, 32'h00000100, target loaded when the fetch timeout error is cleared by a trap with trap_target ignored
TIMEOUT, 16, cycles in WAIT without imem_rvalid before fetch error (range 2..255)

Ports:
clk  in  1  clock
rst  in  1  reset
stall_i  in  1  decode stall; holds the delivered instruction and the PC
trap_valid  in  1  trap redirect pulse
trap_target  in  32  trap handler address
br_valid  in  1  taken-branch redirect pulse
br_target  in  32  branch target
jmp_valid  in  1  jump redirect pulse
jmp_target  in  32  jump target
pc_in  in  32  current PC value
pc_hold  out  1  PC hold control
pc_sel  out  1  1 = PC loads pc_next, 0 = PC +4
pc_next  out  32  redirect address to PC
imem_req  out  1  fetch request
imem_addr  out  32  fetch address
imem_gnt  in  1  request accepted
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction
if_valid  out  1  if_instr/if_pc valid
if_instr  out  32  fetched instruction
if_pc  out  32  address of if_instr
flush_o  out  1  one-cycle pulse on every applied redirect
fetch_err  out  1  sticky fetch-timeout error

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Reset output values:
  - pc_hold=1, pc_sel=0, pc_next=0, imem_req=0, imem_addr=0.
  - if_valid=0, if_instr=32'h00000013 (NOP), if_pc=0.
  - flush_o=0, fetch_err=0.
  - Pending redirect cleared; state IDLE.
- States: IDLE, REQ, WAIT, ISSUE, ERR.
- IDLE: always goes to REQ the next cycle.
- REQ:
  - imem_req=1, imem_addr=pc_in.
  - Request and address stay stable until imem_gnt.
  - On imem_gnt: go to WAIT and capture fetch_pc=pc_in.
- WAIT:
  - imem_req=0; timeout counter increments each cycle.
  - On imem_rvalid with no pending redirect: if_instr<=imem_rdata, if_pc<=fetch_pc, if_valid<=1, go to ISSUE.
  - On imem_rvalid with a pending redirect: discard the response (if_valid stays 0) and go to REQ via the redirect rule.
- ISSUE, stall_i=0: pc_hold=0, pc_sel=0 for exactly this cycle (PC +4); if_valid<=0; go to REQ.
- ISSUE, stall_i=1: pc_hold=1; if_valid and if_instr held.
- PC writes: pc_hold=0 only in the single cycle of a PC update; no other PC writes occur.
- Redirect capture:
  - Redirect inputs are registered into one pending slot (valid, target, priority).
  - Same-cycle pulses resolve trap > branch > jump.
  - A new redirect replaces the pending one only if its priority is equal or higher.
  - Target bits [1:0] are forced to 0.
- Redirect apply:
  - Applied in the first cycle the state is IDLE, ISSUE (regardless of stall_i), or WAIT with imem_rvalid.
  - In that cycle: pc_sel=1, pc_hold=0, pc_next=pending target, flush_o=1, if_valid<=0, pending cleared, next state REQ.
  - Minimum latency is one cycle from the redirect pulse to the PC load.
  - A redirect arriving in REQ does not withdraw the request; the granted response is discarded later.
- Timeout:
  - Counter resets on entering WAIT.
  - When it reaches TIMEOUT without imem_rvalid: go to ERR and set fetch_err=1.
- ERR:
  - imem_req=0, pc_hold=1; a late imem_rvalid is ignored.
  - Non-trap redirects are dropped.
  - A trap pulse loads pc_next=TRAP_VEC with flush_o=1 and goes to REQ; fetch_err stays 1 until rst.
- Wrap-around: pc_in=32'hFFFFFFFC is fetched normally; the next fetch address is 0, because the PC itself wraps.
- Reset mid-transaction: immediate return to reset values; an outstanding response is ignored after reset.

Test Plan:
- Zero-wait memory (gnt in REQ, rvalid the cycle after): three instructions from reset → if_pc 0x0, 0x4, 0x8, each if_valid one cycle, one instruction per 3 cycles.
- stall_i=1 for 4 cycles in ISSUE with if_pc=0x8 → if_valid/if_instr held, pc_hold=1 throughout, PC advances to 0xC only after release.
- br_valid (target 0x40) and jmp_valid (target 0x80) in the same WAIT cycle → response discarded, flush_o pulse, pc_next=0x40, next if_pc=0x40.
- Pending jump 0x80 overridden by trap 0x200 arriving one cycle later → PC loads 0x200; jump target never fetched.
- imem_rvalid withheld for TIMEOUT cycles → fetch_err=1, imem_req=0; subsequent trap pulse → pc_next=0x100, fetching resumes, fetch_err remains 1.
- PC preset near top: fetch at 0xFFFFFFFC → if_pc=0xFFFFFFFC, next imem_addr=0x0; rst asserted during WAIT → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Fetch sequencer for the 32-bit program counter. It walks the instruction
// memory request/grant/response handshake one instruction at a time, hands
// each fetched instruction to the IF/ID boundary, and steers the PC register
// through pc_hold/pc_sel/pc_next. Redirects from trap, branch and jump
// sources are parked in a single pending slot and applied at the next safe
// point in the fetch sequence.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stall_i         decode stall; holds the delivered instruction and the PC
//   trap_valid/target, br_valid/target, jmp_valid/target
//                   redirect pulses and their targets (trap > branch > jump)
//   pc_in           current PC value
//   pc_hold         1 = PC keeps its value this cycle
//   pc_sel          1 = PC loads pc_next, 0 = PC increments by 4
//   pc_next         redirect address for the PC
//   imem_req/addr   fetch request and address
//   imem_gnt        request accepted
//   imem_rvalid/rdata  response strobe and instruction word
//   if_valid/instr/pc  instruction delivered to decode and its address
//   flush_o         one-cycle pulse on every applied redirect
//   fetch_err       sticky fetch-timeout error
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
   parameter logic [31:0] TRAP_VEC = 32'h00000100,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        trap_valid,
   input  logic [31:0] trap_target,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        jmp_valid,
   input  logic [31:0] jmp_target,
   input  logic [31:0] pc_in,
   output logic        pc_hold,
   output logic        pc_sel,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        flush_o,
   output logic        fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ISSUE,
      S_ERR
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);
   localparam logic [1:0]  PRIO_TRAP = 2'd3;
   localparam logic [1:0]  PRIO_BR   = 2'd2;
   localparam logic [1:0]  PRIO_JMP  = 2'd1;

   state_t      state;
   logic        pend_valid;
   logic [31:0] pend_target;
   logic [1:0]  pend_prio;
   logic [31:0] fetch_pc;
   logic [7:0]  tmo_cnt;

   logic        new_valid;
   logic [31:0] new_target;
   logic [1:0]  new_prio;
   logic        apply_redir;
   logic        err_trap;

   // Resolve this cycle's redirect pulses into one candidate. A trap wins
   // over a branch, which wins over a jump. Targets are word-aligned by
   // clearing the two low bits.
   always_comb begin
      new_valid  = trap_valid | br_valid | jmp_valid;
      new_target = 32'h0;
      new_prio   = 2'd0;
      if (trap_valid) begin
         new_target = trap_target & ~32'h3;
         new_prio   = PRIO_TRAP;
      end else if (br_valid) begin
         new_target = br_target & ~32'h3;
         new_prio   = PRIO_BR;
      end else if (jmp_valid) begin
         new_target = jmp_target & ~32'h3;
         new_prio   = PRIO_JMP;
      end
   end

   // A parked redirect may only be applied where no fetch is in flight that
   // would still need its slot: in IDLE, in ISSUE (stalled or not), or in
   // WAIT at the moment the response arrives so that response can be
   // thrown away. In ERR only a live trap pulse gets us out.
   always_comb begin
      apply_redir = pend_valid &&
                    ((state == S_IDLE) || (state == S_ISSUE) ||
                     ((state == S_WAIT) && imem_rvalid));
      err_trap    = (state == S_ERR) && trap_valid;
   end

   // PC and memory controls have to follow pc_in and imem_rvalid within the
   // same cycle (the PC register loads on the edge that ends the cycle, and
   // the request address must track the PC it just loaded), so they are
   // decoded from the registered state rather than being registers
   // themselves. The PC is written only on a redirect or on a non-stalled
   // ISSUE; every other cycle it is held.
   always_comb begin
      pc_hold   = 1'b1;
      pc_sel    = 1'b0;
      pc_next   = 32'h0;
      flush_o   = 1'b0;
      imem_req  = 1'b0;
      imem_addr = 32'h0;
      if (apply_redir) begin
         pc_hold = 1'b0;
         pc_sel  = 1'b1;
         pc_next = pend_target;
         flush_o = 1'b1;
      end else if (err_trap) begin
         pc_hold = 1'b0;
         pc_sel  = 1'b1;
         pc_next = TRAP_VEC;
         flush_o = 1'b1;
      end else if ((state == S_ISSUE) && !stall_i) begin
         pc_hold = 1'b0;
      end
      if (state == S_REQ) begin
         imem_req  = 1'b1;
         imem_addr = pc_in;
      end
   end

   // Main fetch sequencer. Besides the state it owns the pending redirect
   // slot, the captured fetch address, the timeout counter and everything
   // delivered to decode. The pending slot is refilled in the same cycle it
   // is applied so a pulse landing on that cycle is not lost, and it is
   // emptied while in ERR because only a trap pulse is honoured there.
   // Timeout counts WAIT cycles since the grant; TIMEOUT such cycles
   // without a response move the sequencer to ERR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         pend_valid  <= 1'b0;
         pend_target <= 32'h0;
         pend_prio   <= 2'd0;
         fetch_pc    <= 32'h0;
         tmo_cnt     <= 8'd0;
         if_valid    <= 1'b0;
         if_instr    <= NOP_INSTR;
         if_pc       <= 32'h0;
         fetch_err   <= 1'b0;
      end else begin
         if (state == S_ERR) begin
            pend_valid <= 1'b0;
         end else if (apply_redir) begin
            pend_valid  <= new_valid;
            pend_target <= new_target;
            pend_prio   <= new_prio;
         end else if (new_valid && (!pend_valid || (new_prio >= pend_prio))) begin
            pend_valid  <= 1'b1;
            pend_target <= new_target;
            pend_prio   <= new_prio;
         end

         case (state)
            S_IDLE: begin
               state <= S_REQ;
            end
            S_REQ: begin
               if (imem_gnt) begin
                  state    <= S_WAIT;
                  fetch_pc <= pc_in;
                  tmo_cnt  <= 8'd0;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (apply_redir) begin
                     state <= S_REQ;
                  end else begin
                     if_instr <= imem_rdata;
                     if_pc    <= fetch_pc;
                     if_valid <= 1'b1;
                     state    <= S_ISSUE;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state     <= S_ERR;
                  fetch_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_ISSUE: begin
               if (apply_redir || !stall_i) begin
                  if_valid <= 1'b0;
                  state    <= S_REQ;
               end
            end
            S_ERR: begin
               if (trap_valid) begin
                  state <= S_REQ;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Directed bench for pc_fetch_ctrl. The bench owns a PC register that obeys
// pc_hold/pc_sel/pc_next (with a preset hook to jump near the top of the
// address space) and a simple instruction memory that grants in REQ and
// answers the cycle after the grant with instr = addr ^ 32'h5A5A0000.
// The response can be withheld and the grant blocked from the stimulus.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        trap_valid;
   logic [31:0] trap_target;
   logic        br_valid;
   logic [31:0] br_target;
   logic        jmp_valid;
   logic [31:0] jmp_target;
   logic [31:0] pc_in;
   logic        pc_hold;
   logic        pc_sel;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush_o;
   logic        fetch_err;

   logic        gnt_en;
   logic        rv_en;
   logic        preset_en;
   logic [31:0] preset_val;
   logic [31:0] pc_q;
   logic        resp_pend;
   logic [31:0] resp_addr;

   int checks = 0;
   int errors = 0;
   int n;

   pc_fetch_ctrl #(
      .TRAP_VEC(32'h00000100),
      .TIMEOUT (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall_i),
      .trap_valid (trap_valid),
      .trap_target(trap_target),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .jmp_valid  (jmp_valid),
      .jmp_target (jmp_target),
      .pc_in      (pc_in),
      .pc_hold    (pc_hold),
      .pc_sel     (pc_sel),
      .pc_next    (pc_next),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .flush_o    (flush_o),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   // PC register driven by the controller's hold/select/next outputs.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= 32'h0;
      end else if (preset_en) begin
         pc_q <= preset_val;
      end else if (!pc_hold) begin
         pc_q <= pc_sel ? pc_next : pc_q + 32'd4;
      end
   end

   assign pc_in = pc_q;

   // Instruction memory: grants while enabled, answers after the grant and
   // keeps the response pending until it is presented with rvalid.
   assign imem_gnt    = imem_req & gnt_en;
   assign imem_rvalid = resp_pend & rv_en;
   assign imem_rdata  = resp_addr ^ 32'h5A5A0000;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_pend <= 1'b0;
         resp_addr <= 32'h0;
      end else if (imem_gnt) begin
         resp_pend <= 1'b1;
         resp_addr <= imem_addr;
      end else if (imem_rvalid) begin
         resp_pend <= 1'b0;
      end
   end

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge, then let the
   // combinational outputs settle before anything is sampled.
   task automatic applyStimulus(input logic st,
                                input logic tv, input logic [31:0] tt,
                                input logic bv, input logic [31:0] bt,
                                input logic jv, input logic [31:0] jt);
      @(negedge clk);
      stall_i     = st;
      trap_valid  = tv;
      trap_target = tt;
      br_valid    = bv;
      br_target   = bt;
      jmp_valid   = jv;
      jmp_target  = jt;
      #1;
   endtask

   task automatic idleCycle(input logic st);
      applyStimulus(st, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Step cycles until an instruction is delivered, bounded by a budget.
   task automatic waitIssue(input logic st, output int cycles);
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
         idleCycle(st);
         cycles++;
         if (if_valid) break;
      end
      checkOutput("issue_seen", 32'(if_valid), 32'd1);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_pc_hold"},   32'(pc_hold),   32'd1);
      checkOutput({tag, "_pc_sel"},    32'(pc_sel),    32'd0);
      checkOutput({tag, "_pc_next"},   pc_next,        32'h0);
      checkOutput({tag, "_imem_req"},  32'(imem_req),  32'd0);
      checkOutput({tag, "_imem_addr"}, imem_addr,      32'h0);
      checkOutput({tag, "_if_valid"},  32'(if_valid),  32'd0);
      checkOutput({tag, "_if_instr"},  if_instr,       32'h00000013);
      checkOutput({tag, "_if_pc"},     if_pc,          32'h0);
      checkOutput({tag, "_flush"},     32'(flush_o),   32'd0);
      checkOutput({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      stall_i = 1'b0;
      trap_valid = 1'b0;
      trap_target = 32'h0;
      br_valid = 1'b0;
      br_target = 32'h0;
      jmp_valid = 1'b0;
      jmp_target = 32'h0;
      gnt_en = 1'b1;
      rv_en = 1'b1;
      preset_en = 1'b0;
      preset_val = 32'h0;
      #2;
      checkReset("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Zero-wait fetches from reset: 0x0, 0x4, 0x8 at one per 3 cycles.
      waitIssue(1'b0, n);
      checkOutput("first_lat", 32'(n), 32'd3);
      checkOutput("if_pc0", if_pc, 32'h0);
      checkOutput("if_instr0", if_instr, 32'h5A5A0000);
      checkOutput("issue_pc_hold", 32'(pc_hold), 32'd0);
      checkOutput("issue_pc_sel", 32'(pc_sel), 32'd0);
      waitIssue(1'b0, n);
      checkOutput("rate1", 32'(n), 32'd3);
      checkOutput("if_pc4", if_pc, 32'h4);
      checkOutput("if_instr4", if_instr, 32'h5A5A0004);

      // Stall the third instruction in ISSUE for four cycles.
      waitIssue(1'b1, n);
      checkOutput("rate2", 32'(n), 32'd3);
      checkOutput("if_pc8", if_pc, 32'h8);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) idleCycle(1'b1);
         checkOutput("stall_valid", 32'(if_valid), 32'd1);
         checkOutput("stall_instr", if_instr, 32'h5A5A0008);
         checkOutput("stall_hold", 32'(pc_hold), 32'd1);
         checkOutput("stall_pc", pc_in, 32'h8);
      end
      idleCycle(1'b0);
      checkOutput("release_hold", 32'(pc_hold), 32'd0);
      checkOutput("release_sel", 32'(pc_sel), 32'd0);
      idleCycle(1'b0);
      checkOutput("addr_c", imem_addr, 32'hC);
      checkOutput("req_c", 32'(imem_req), 32'd1);
      checkOutput("valid_drop", 32'(if_valid), 32'd0);
      rv_en = 1'b0;

      // Branch and jump together in WAIT: branch wins, response discarded.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h80);
      checkOutput("brj_noflush0", 32'(flush_o), 32'd0);
      idleCycle(1'b0);
      checkOutput("brj_noflush1", 32'(flush_o), 32'd0);
      rv_en = 1'b1;
      #1;
      checkOutput("brj_flush", 32'(flush_o), 32'd1);
      checkOutput("brj_sel", 32'(pc_sel), 32'd1);
      checkOutput("brj_hold", 32'(pc_hold), 32'd0);
      checkOutput("brj_next", pc_next, 32'h40);
      idleCycle(1'b0);
      checkOutput("brj_addr", imem_addr, 32'h40);
      checkOutput("brj_discard", 32'(if_valid), 32'd0);
      checkOutput("brj_flush_end", 32'(flush_o), 32'd0);
      waitIssue(1'b0, n);
      checkOutput("brj_if_pc", if_pc, 32'h40);
      checkOutput("brj_if_instr", if_instr, 32'h5A5A0040);
      rv_en = 1'b0;

      // Pending jump replaced by a trap arriving one cycle later.
      idleCycle(1'b0);
      checkOutput("addr_44", imem_addr, 32'h44);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80);
      applyStimulus(1'b0, 1'b1, 32'h202, 1'b0, 32'h0, 1'b0, 32'h0);
      idleCycle(1'b0);
      checkOutput("trap_noflush", 32'(flush_o), 32'd0);
      rv_en = 1'b1;
      #1;
      checkOutput("trap_flush", 32'(flush_o), 32'd1);
      checkOutput("trap_next", pc_next, 32'h200);
      idleCycle(1'b0);
      checkOutput("trap_addr", imem_addr, 32'h200);
      waitIssue(1'b0, n);
      checkOutput("trap_if_pc", if_pc, 32'h200);
      rv_en = 1'b0;

      // Withhold the response for TIMEOUT cycles.
      idleCycle(1'b0);
      checkOutput("addr_204", imem_addr, 32'h204);
      for (int i = 0; i < 16; i++) idleCycle(1'b0);
      checkOutput("tmo_not_yet", 32'(fetch_err), 32'd0);
      idleCycle(1'b0);
      checkOutput("tmo_err", 32'(fetch_err), 32'd1);
      checkOutput("tmo_req", 32'(imem_req), 32'd0);
      checkOutput("tmo_hold", 32'(pc_hold), 32'd1);
      rv_en = 1'b1;
      idleCycle(1'b0);
      checkOutput("err_late_rvalid", 32'(if_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0);
      checkOutput("err_br_flush", 32'(flush_o), 32'd0);
      checkOutput("err_br_hold", 32'(pc_hold), 32'd1);
      applyStimulus(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("err_trap_next", pc_next, 32'h100);
      checkOutput("err_trap_flush", 32'(flush_o), 32'd1);
      checkOutput("err_trap_sel", 32'(pc_sel), 32'd1);
      checkOutput("err_trap_hold", 32'(pc_hold), 32'd0);
      idleCycle(1'b0);
      checkOutput("err_resume_addr", imem_addr, 32'h100);
      waitIssue(1'b0, n);
      checkOutput("err_resume_pc", if_pc, 32'h100);
      checkOutput("err_sticky", 32'(fetch_err), 32'd1);

      // Preset the PC to the top word and check the wrap to zero.
      gnt_en = 1'b0;
      idleCycle(1'b0);
      checkOutput("addr_104", imem_addr, 32'h104);
      preset_en = 1'b1;
      preset_val = 32'hFFFFFFFC;
      idleCycle(1'b0);
      checkOutput("addr_top", imem_addr, 32'hFFFFFFFC);
      preset_en = 1'b0;
      gnt_en = 1'b1;
      waitIssue(1'b0, n);
      checkOutput("top_if_pc", if_pc, 32'hFFFFFFFC);
      checkOutput("top_if_instr", if_instr, 32'hA5A5FFFC);
      rv_en = 1'b0;
      idleCycle(1'b0);
      checkOutput("wrap_addr", imem_addr, 32'h0);

      // Reset asserted in the middle of WAIT.
      idleCycle(1'b0);
      checkOutput("wait_req", 32'(imem_req), 32'd0);
      rst = 1'b1;
      #1;
      checkReset("midrst");
      @(negedge clk);
      @(negedge clk);
      rv_en = 1'b1;
      rst = 1'b0;
      waitIssue(1'b0, n);
      checkOutput("post_rst_lat", 32'(n), 32'd3);
      checkOutput("post_rst_pc", if_pc, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
